// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding reads to imem,
// and offers {PC+4, instruction} to IF/ID through an out slot plus a 1-entry skid slot.
//
// state | meaning
// FETCH | normal fetching
// DROP  | old request still outstanding after a redirect; its response is discarded
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CStall,
  input  logic        CRedirect,
  input  logic [31:0] IRedirectPC,
  output logic        OImemReq,
  output logic [31:0] OImemAddr,
  input  logic        IImemReady,
  input  logic [31:0] IImemData,
  output logic [31:0] OPCAdd4,
  output logic [31:0] OInst,
  output logic        OValid
);

  typedef enum logic {FETCH = 1'b0, DROP = 1'b1} state_t;

  state_t      state, state_nx;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic [31:0] pc_add4;
  logic        ov;
  logic [31:0] opc4;
  logic [31:0] oinst;
  logic        sv;
  logic [31:0] spc4;
  logic [31:0] sinst;
  logic        xfer;
  logic        xfer_fetch;
  logic        enter_drop;
  logic [1:0]  unused_redirect_lsb;

  assign unused_redirect_lsb = IRedirectPC[1:0];
  assign pc_add4 = pc + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nx;
  end

  // reset gates the request combinationally so an in-flight read is dropped at once
  always_comb begin
    state_nx   = state;
    OImemReq   = 1'b0;
    OImemAddr  = pc;
    enter_drop = 1'b0;
    case (state)
      FETCH: begin
        OImemReq = reset && !sv;
        if (CRedirect && OImemReq && !IImemReady) begin
          enter_drop = 1'b1;
          state_nx   = DROP;
        end
      end
      DROP: begin
        OImemReq  = reset;
        OImemAddr = drop_addr;
        if (IImemReady) state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  assign xfer       = OImemReq && IImemReady;
  assign xfer_fetch = xfer && (state == FETCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      drop_addr <= 32'h0;
      ov        <= 1'b0;
      opc4      <= 32'h0;
      oinst     <= 32'h0;
      sv        <= 1'b0;
      spc4      <= 32'h0;
      sinst     <= 32'h0;
    end else begin
      if (enter_drop) drop_addr <= pc;
      if (CRedirect) begin
        pc    <= {IRedirectPC[31:2], 2'b00};
        ov    <= 1'b0;
        oinst <= 32'h0;
        sv    <= 1'b0;
      end else begin
        if (xfer_fetch) pc <= pc_add4;
        if (!CStall) begin
          if (sv) begin
            ov    <= 1'b1;
            opc4  <= spc4;
            oinst <= sinst;
            sv    <= 1'b0;
          end else if (xfer_fetch) begin
            ov    <= 1'b1;
            opc4  <= pc_add4;
            oinst <= IImemData;
          end else begin
            ov    <= 1'b0;
            oinst <= 32'h0;
          end
        end else if (xfer_fetch) begin
          // stalled: land in the out slot if it is empty, otherwise park in skid
          if (!ov) begin
            ov    <= 1'b1;
            opc4  <= pc_add4;
            oinst <= IImemData;
          end else begin
            sv    <= 1'b1;
            spc4  <= pc_add4;
            sinst <= IImemData;
          end
        end
      end
    end
  end

  assign OValid  = ov;
  assign OPCAdd4 = opc4;
  assign OInst   = oinst;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic, checked every
// cycle against a queue-based model of the fetch buffer.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        CStall;
  logic        CRedirect;
  logic [31:0] IRedirectPC;
  logic        OImemReq;
  logic [31:0] OImemAddr;
  logic        IImemReady;
  logic [31:0] IImemData;
  logic [31:0] OPCAdd4;
  logic [31:0] OInst;
  logic        OValid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_drop;
  logic [31:0] m_drop_addr;
  logic [31:0] m_last;
  logic        m_in_reset;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .CStall(CStall), .CRedirect(CRedirect),
    .IRedirectPC(IRedirectPC), .OImemReq(OImemReq), .OImemAddr(OImemAddr),
    .IImemReady(IImemReady), .IImemData(IImemData), .OPCAdd4(OPCAdd4),
    .OInst(OInst), .OValid(OValid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3} | 32'h1;
  endfunction

  assign IImemData = mem_word(OImemAddr);

  function automatic logic m_req();
    return !m_in_reset && (m_drop || (m_q.size() < 2));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_req;
    exp_req = m_req();
    chk("req", {31'b0, OImemReq}, {31'b0, exp_req});
    if (exp_req) chk("addr", OImemAddr, m_drop ? m_drop_addr : m_pc);
    chk("valid", {31'b0, OValid}, {31'b0, (m_q.size() > 0)});
    chk("inst", OInst, (m_q.size() > 0) ? m_q[0].inst : 32'h0);
    chk("pc4", OPCAdd4, (m_q.size() > 0) ? m_q[0].pc4 : m_last);
  endtask

  // called at a negedge; applies inputs, checks, then advances model over one posedge
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic xf;
    ent_t e;
    CStall = st; CRedirect = rd; IRedirectPC = rpc; IImemReady = rdy;
    #1;
    check_outputs();
    xf = m_req() && rdy;
    @(posedge clk);
    if (rd) begin
      if (m_drop) begin
        if (rdy) m_drop = 1'b0;
      end else if (m_req() && !rdy) begin
        m_drop      = 1'b1;
        m_drop_addr = m_pc;
      end
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (m_drop) begin
      if (rdy) m_drop = 1'b0;
    end else begin
      if (!st && m_q.size() > 0) void'(m_q.pop_front());
      if (xf) begin
        e.pc4  = m_pc + 32'd4;
        e.inst = mem_word(m_pc);
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    if (m_q.size() > 0) m_last = m_q[0].pc4;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_q.delete();
    m_pc = 32'h0; m_drop = 1'b0; m_drop_addr = 32'h0; m_last = 32'h0; m_in_reset = 1'b1;
    check_outputs();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b1;
    m_in_reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; CStall = 1'b0; CRedirect = 1'b0; IRedirectPC = 32'h0; IImemReady = 1'b0;
    m_in_reset = 1'b1;
    @(negedge clk);
    do_reset();

    // zero-wait streaming
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    // two wait states per fetch
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'h0, (i % 3) == 2);
    // stall three cycles with zero-wait memory, then release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    // redirect to 0x103 while a waiting request is outstanding
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("pre_redirect_addr", OImemAddr, 32'h10);
    step(1'b0, 1'b1, 32'h103, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    // redirect together with stall and a same-cycle transfer
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    // PC wrap past 32'hFFFF_FFFC
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    // reset during a waiting request at 0x8
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wait_addr", OImemAddr, 32'h8);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8,
           $urandom & 32'h0000_0FFF, $urandom_range(0, 9) < 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that drives the IF/ID pipeline register.
- Owns the PC and issues one-outstanding-request reads to instruction memory, which may insert wait states.
- Offers {PC+4, instruction} to IF/ID, honouring the same CStall used by IF/ID.
- Applies branch/jump redirects with bubble insertion and discard of in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset (bits [1:0] must be 0)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; all state cleared while low
CStall  input  1  IF/ID hold; offered instruction not consumed this cycle
CRedirect  input  1  taken branch/jump; restart fetch at IRedirectPC
IRedirectPC  input  32  redirect target; bits [1:0] ignored (forced 00)
OImemReq  output  1  memory read request
OImemAddr  output  32  word-aligned fetch address
IImemReady  input  1  read data valid; transfer = OImemReq && IImemReady
IImemData  input  32  instruction word, valid on transfer
OPCAdd4  output  32  PC+4 of offered instruction, to IF/ID IPCAdd4
OInst  output  32  offered instruction, to IF/ID IInst; 32'b0 (nop) when no valid instruction
OValid  output  1  OInst/OPCAdd4 hold a real instruction

Behaviour:
- Reset (reset low): PC=RESET_PC; state=FETCH; out slot and skid slot empty; OValid=0, OInst=0, OPCAdd4=0; OImemReq=0 while reset is low.
- Storage: out slot {OValid,OPCAdd4,OInst} plus 1-entry skid slot {sv,spc4,sinst}.
- FSM states:
  - FETCH: normal fetching.
  - DROP: waiting to discard a stale response.
- Request rule:
  - A new request starts only when state=FETCH and sv=0.
  - Once asserted, OImemReq stays high and OImemAddr stays stable (=PC at start) until transfer; no withdrawal except by reset.
  - OImemAddr = PC whenever OImemReq=1.
- Transfer in FETCH: PC <= PC+4. Data {PC+4, IImemData} goes to:
  - the out slot, if the out slot is empty or being consumed (CStall=0); else
  - the skid slot (guaranteed empty by the request rule).
- Consumption: at each edge with CStall=0 and no redirect, the out slot is consumed and refilled in priority order:
  1. from the skid slot, if sv=1 (sv cleared);
  2. otherwise from the same-cycle transfer;
  3. otherwise the out slot becomes a bubble: OValid=0, OInst=0, OPCAdd4 held.
- CStall=1: out slot holds exactly; a transfer may still land in skid; no new request while sv=1.
- Zero-wait memory (ready in the request cycle) sustains 1 instruction/cycle; first OValid=1 is 1 cycle after the first transfer edge.
- Redirect (CRedirect=1 at an edge), highest priority, overrides CStall and any same-cycle transfer:
  - Out and skid slots are cleared (OValid=0, OInst=0, sv=0).
  - PC <= {IRedirectPC[31:2],2'b00}.
  - If a request is outstanding with no transfer this cycle: state <= DROP.
  - Otherwise: remain in FETCH and request the target next cycle.
- DROP:
  - OImemReq is held to the old address until transfer; the data is discarded and PC is unchanged.
  - Then state returns to FETCH and the target request issues next cycle.
  - A further CRedirect while in DROP updates PC only; state stays DROP.
- Reset asserted mid-request: request abandoned immediately; the memory must tolerate the drop.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.

Test Plan:
- Zero-wait memory (IImemReady=1 constant), RESET_PC=0 -> addresses 0,4,8,…; OPCAdd4 4,8,12,… on consecutive cycles; OValid=1 from cycle 2 after reset release.
- 2-wait-state memory -> OImemReq/OImemAddr stable for 3 cycles per fetch; OValid pulses once per 3 cycles with bubbles (OInst=0) between.
- CStall high 3 cycles with zero-wait memory -> OInst frozen; one word captured in skid; OImemReq low while sv=1; after release, skid word appears next; no instruction lost or duplicated.
- CRedirect with IRedirectPC=32'h103 while a 2-wait request to 0x10 is outstanding -> OValid=0 next cycle; the 0x10 response is discarded; next OImemAddr=0x100; OPCAdd4=0x104 offered.
- CRedirect and CStall together with zero-wait transfer -> redirect wins: both slots empty, transfer data dropped, PC=target.
- Reset pulled low during a waiting request at 0x8 -> OImemReq=0, OValid=0 immediately; after release, fetch restarts at RESET_PC.
